// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared types and helpers for the 2x2 max-pool layer.
// Holds the element width, the stride-1 sequencing states and the
// per-element floating-point maximum used by every compare lane.
package maxpool_pkg;

  // Element width of one channel value (IEEE-754 single precision).
  localparam int FP_WIDTH = 32;

  // Stride-1 sequencing: stream the frame, then flush the last row.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pool_state_e;

  // Larger of two single-precision values using sign-magnitude ordering.
  // NaNs are never presented; +0 and -0 compare equal, so either may win.
  function automatic logic [FP_WIDTH-1:0] fp32_max(input logic [FP_WIDTH-1:0] a,
                                                   input logic [FP_WIDTH-1:0] b);
    logic a_ge_b;
    if (a[FP_WIDTH-1] != b[FP_WIDTH-1]) begin
      a_ge_b = ~a[FP_WIDTH-1];
    end else if (!a[FP_WIDTH-1]) begin
      a_ge_b = (a[FP_WIDTH-2:0] >= b[FP_WIDTH-2:0]);
    end else begin
      a_ge_b = (a[FP_WIDTH-2:0] <= b[FP_WIDTH-2:0]);
    end
    return a_ge_b ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// maxpool_line_buffer: one image row of full-width pixels.
// Two asynchronous read ports and one synchronous write port. A read and a
// write to the same index in one cycle return the old contents, which is how
// the layer fetches the previous row's pixel while storing the current one.
module maxpool_line_buffer
  import maxpool_pkg::*;
#(
  parameter int DEPTH = 104,
  parameter int WIDTH = 64 * FP_WIDTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];

  // Row storage: contents are overwritten before use, so no reset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/maxpool_layer.sv
// maxpool_layer: channel-parallel 2x2 max pool on a raster pixel stream.
// One row/column controller, one line buffer and one output register serve
// all channels. STRIDE 2 halves the image; STRIDE 1 keeps it N x N with the
// right/bottom edge replicated, which needs a flush of the last row after
// each frame. Stride-1 logic is compiled only with MAXPOOL_STRIDE1_EN.
module maxpool_layer
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 64,
  parameter int IMG_SIZE   = 104,
  parameter int STRIDE     = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out
);

  localparam int BUS_W = CHANNELS * DATA_WIDTH;
  localparam int IDX_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);

  // Reject configurations the datapath cannot build.
  generate
    if (DATA_WIDTH != FP_WIDTH) begin : g_bad_width
      $error("maxpool_layer: DATA_WIDTH must be 32");
    end
    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
      $error("maxpool_layer: STRIDE must be 1 or 2");
    end
    if (STRIDE == 2 && (IMG_SIZE % 2) != 0) begin : g_bad_size
      $error("maxpool_layer: IMG_SIZE must be even for STRIDE 2");
    end
`ifndef MAXPOOL_STRIDE1_EN
    if (STRIDE == 1) begin : g_no_stride1
      $error("maxpool_layer: STRIDE 1 requires MAXPOOL_STRIDE1_EN");
    end
`endif
  endgenerate

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             win_hit;
  logic [IDX_W-1:0] row_reg;
  logic [IDX_W-1:0] col_reg;
  logic [BUS_W-1:0] prev_cur_reg;   // left neighbour in the current row
  logic [BUS_W-1:0] prev_up_reg;    // left neighbour in the previous row
  logic [BUS_W-1:0] lb_rd_a;
  logic [BUS_W-1:0] lb_rd_b;
  logic [IDX_W-1:0] lb_idx_a;
  logic [IDX_W-1:0] lb_idx_b;
  logic [BUS_W-1:0] win_max;        // max of the full 2x2 window
  logic [BUS_W-1:0] pair_max;       // max of two pixels (edge replication)
  logic [BUS_W-1:0] pair_b;

  // Stride-1 control, constant in the stride-2-only build.
  logic             in_drain;
  logic [IDX_W-1:0] drain_col;
  logic             drain_emit;
  logic             pend_emit;
  logic [BUS_W-1:0] pend_data;

  assign accept   = valid_in & ready_out;
  assign col_last = (col_reg == LAST_IDX);
  assign row_last = (row_reg == LAST_IDX);

  // A full window completes on odd/odd pixels for stride 2 and on every
  // pixel past the first row and column for stride 1.
  always_comb begin
    win_hit = 1'b0;
    if (accept) begin
      if (STRIDE == 2) begin
        win_hit = row_reg[0] & col_reg[0];
      end else begin
        win_hit = (row_reg != '0) && (col_reg != '0);
      end
    end
  end

  // Raster position of the next accepted beat; wraps so frames run back-to-back.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + IDX_W'(1);
      end else begin
        col_reg <= col_reg + IDX_W'(1);
      end
    end
  end

  // Remember the left-hand column of the window for the next beat.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prev_cur_reg <= '0;
      prev_up_reg  <= '0;
    end else if (accept) begin
      prev_cur_reg <= data_in;
      prev_up_reg  <= lb_rd_a;
    end
  end

  // Port A reads the pixel above while streaming, or the drained column;
  // port B reads its right neighbour, clamped at the last column.
  assign lb_idx_a = in_drain ? drain_col : col_reg;
  assign lb_idx_b = (drain_col == LAST_IDX) ? drain_col : drain_col + IDX_W'(1);
  assign pair_b   = in_drain ? lb_rd_b : data_in;

  maxpool_line_buffer #(
    .DEPTH (IMG_SIZE),
    .WIDTH (BUS_W),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .Clk       (Clk),
    .wr_en     (accept),
    .wr_idx    (col_reg),
    .wr_data   (data_in),
    .rd_idx_a  (lb_idx_a),
    .rd_data_a (lb_rd_a),
    .rd_idx_b  (lb_idx_b),
    .rd_data_b (lb_rd_b)
  );

  // One compare lane per channel.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] top_max;
      logic [DATA_WIDTH-1:0] bot_max;
      assign top_max = fp32_max(prev_up_reg[gi*DATA_WIDTH +: DATA_WIDTH],
                                lb_rd_a[gi*DATA_WIDTH +: DATA_WIDTH]);
      assign bot_max = fp32_max(prev_cur_reg[gi*DATA_WIDTH +: DATA_WIDTH],
                                data_in[gi*DATA_WIDTH +: DATA_WIDTH]);
      assign win_max[gi*DATA_WIDTH +: DATA_WIDTH]  = fp32_max(top_max, bot_max);
      assign pair_max[gi*DATA_WIDTH +: DATA_WIDTH] =
        fp32_max(lb_rd_a[gi*DATA_WIDTH +: DATA_WIDTH], pair_b[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

`ifdef MAXPOOL_STRIDE1_EN
  localparam int CNT_W = $clog2(IMG_SIZE + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IMG_SIZE);

  pool_state_e      state_reg;
  pool_state_e      state_next;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic             pend_valid_reg;
  logic [BUS_W-1:0] pend_reg;

  // Drain cycle 0 flushes the pending pixel; cycles 1..N walk row N-1.
  assign drain_col = IDX_W'(drain_cnt_reg - CNT_W'(1));
  assign pend_emit = pend_valid_reg;
  assign pend_data = pend_reg;

  // Sequencing state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and drain-phase control outputs.
  always_comb begin
    state_next = state_reg;
    ready_out  = 1'b1;
    in_drain   = 1'b0;
    drain_emit = 1'b0;
    case (state_reg)
      RUN: begin
        if (STRIDE == 1 && accept && row_last && col_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        ready_out  = 1'b0;
        in_drain   = 1'b1;
        drain_emit = (drain_cnt_reg != '0);
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Counts drain cycles; idles at zero outside DRAIN.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      drain_cnt_reg <= '0;
    end else if (in_drain && drain_cnt_reg != DRAIN_LAST) begin
      drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
    end else begin
      drain_cnt_reg <= '0;
    end
  end

  // Last-column output of the row above, held one cycle so it never
  // collides with the window output of the same beat.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend_valid_reg <= 1'b0;
      pend_reg       <= '0;
    end else if (STRIDE == 1 && accept && col_last && row_reg != '0) begin
      pend_valid_reg <= 1'b1;
      pend_reg       <= pair_max;
    end else begin
      pend_valid_reg <= 1'b0;
    end
  end
`else
  assign ready_out  = 1'b1;
  assign in_drain   = 1'b0;
  assign drain_col  = '0;
  assign drain_emit = 1'b0;
  assign pend_emit  = 1'b0;
  assign pend_data  = '0;
`endif

  // Registered output; the three sources never fire in the same cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (win_hit) begin
        data_out  <= win_max;
        valid_out <= 1'b1;
      end else if (pend_emit) begin
        data_out  <= pend_data;
        valid_out <= 1'b1;
      end else if (drain_emit) begin
        data_out  <= pair_max;
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// tb_maxpool_layer: directed bench with an output scoreboard.
// Stride-2 instance (N=4, 2 channels) always; stride-1 instance (N=3)
// when MAXPOOL_STRIDE1_EN is defined.
module tb_maxpool_layer;

  localparam int CH = 2;
  localparam int BW = CH * 32;

  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] mask;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [BW-1:0] s2_din, s1_din;
  logic          s2_vin, s1_vin;
  logic [BW-1:0] s2_dout, s1_dout;
  logic          s2_vout, s1_vout, s2_rdy, s1_rdy;

  maxpool_layer #(.DATA_WIDTH(32), .CHANNELS(CH), .IMG_SIZE(4), .STRIDE(2)) u_s2 (
    .Clk(clk), .Rst(rst_n), .data_in(s2_din), .valid_in(s2_vin),
    .ready_out(s2_rdy), .data_out(s2_dout), .valid_out(s2_vout)
  );

`ifdef MAXPOOL_STRIDE1_EN
  maxpool_layer #(.DATA_WIDTH(32), .CHANNELS(CH), .IMG_SIZE(3), .STRIDE(1)) u_s1 (
    .Clk(clk), .Rst(rst_n), .data_in(s1_din), .valid_in(s1_vin),
    .ready_out(s1_rdy), .data_out(s1_dout), .valid_out(s1_vout)
  );
`else
  assign s1_dout = '0;
  assign s1_vout = 1'b0;
  assign s1_rdy  = 1'b1;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  logic [BW-1:0] mon_dout;
  logic          mon_vout, mon_rdy;
  always_comb begin
    mon_dout = (sel == 1) ? s1_dout : s2_dout;
    mon_vout = (sel == 1) ? s1_vout : s2_vout;
    mon_rdy  = (sel == 1) ? s1_rdy  : s2_rdy;
  end

  int          pv [4][4][CH];
  logic [31:0] pb [4][4][CH];

  // Small integer to single-precision bit pattern (|v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    int unsigned m;
    int          p;
    logic [31:0] sh;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    sh = m << (23 - p);
    return {(v < 0), 8'(127 + p), sh[22:0]};
  endfunction

  task automatic fill(input int n, input int off);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        pv[r][c][0] = n * r + c + off;
        pv[r][c][1] = -(n * r + c + 1) + off;
        for (int k = 0; k < CH; k++) pb[r][c][k] = i2f(pv[r][c][k]);
      end
  endtask

  // Expected pixel: max over rows r0..r0+1, cols c0..c0+1, clamped to n-1.
  task automatic push(input int n, input int r0, input int c0, input int due);
    exp_t e;
    for (int k = 0; k < CH; k++) begin
      int best = -2147483647;
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          int rr = (r0 + dr > n - 1) ? n - 1 : r0 + dr;
          int cc = (c0 + dc > n - 1) ? n - 1 : c0 + dc;
          if (pv[rr][cc][k] > best) best = pv[rr][cc][k];
        end
      e.data[k*32 +: 32] = i2f(best);
      e.mask[k*32 +: 32] = (best == 0) ? 32'h7fffffff : 32'hffffffff;
    end
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [BW-1:0] d);
    if (sel == 1) begin s1_vin = v; s1_din = d; end
    else          begin s2_vin = v; s2_din = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends up to nbeats pixels of an n x n frame, holding valid until ready.
  task automatic send_frame(input int n, input int stride, input int gap, input int nbeats);
    int b = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (b < nbeats) begin
          int g = 0;
          int a;
          drive(1'b1, {pb[r][c][1], pb[r][c][0]});
          while (!mon_rdy && g < 40) begin @(posedge clk); #1; g++; end
          n_cmp++;
          assert (mon_rdy === 1'b1) else begin
            n_bad++; $error("FAIL ready_wait r=%0d c=%0d ready=%b expected 1", r, c, mon_rdy);
          end
          a = cyc;
          if (stride == 2) begin
            if ((r % 2 == 1) && (c % 2 == 1)) push(n, r - 1, c - 1, a + 1);
          end else begin
            if (r >= 1 && c >= 1) push(n, r - 1, c - 1, a + 1);
            if (r >= 1 && c == n - 1) push(n, r - 1, n - 1, a + 2);
            if (r == n - 1 && c == n - 1)
              for (int k = 0; k < n; k++) push(n, n - 1, k, a + 3 + k);
          end
          @(posedge clk); #1;
          drive(1'b0, '0);
          idle(gap);
          b++;
        end
      end
  endtask

  task automatic check_reset_state(input string tag);
    n_cmp++;
    assert (mon_vout === 1'b0) else begin
      n_bad++; $error("FAIL %s_valid got=%b expected 0", tag, mon_vout);
    end
    n_cmp++;
    assert (mon_dout === '0) else begin
      n_bad++; $error("FAIL %s_data got=%h expected 0", tag, mon_dout);
    end
    n_cmp++;
    assert (mon_rdy === 1'b1) else begin
      n_bad++; $error("FAIL %s_ready got=%b expected 1", tag, mon_rdy);
    end
  endtask

  // Scoreboard: every valid_out pops one expectation; overdue ones are misses.
  always @(negedge clk) begin
    exp_t e;
    if (mon_vout) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_bad++; $error("FAIL unexpected_out cyc=%0d got=%h expected no output", cyc, mon_dout);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert ((mon_dout & e.mask) === (e.data & e.mask)) else begin
          n_bad++; $error("FAIL out_data cyc=%0d got=%h expected %h", cyc, mon_dout, e.data);
        end
        n_cmp++;
        assert (cyc === e.due) else begin
          n_bad++; $error("FAIL out_timing got_cycle=%0d expected_cycle=%0d", cyc, e.due);
        end
        $display("out cyc=%0d data=%h expected=%h", cyc, mon_dout, e.data);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      assert (mon_vout === 1'b1) else begin
        n_bad++; $error("FAIL missing_out cyc=%0d valid=%b expected 1 data=%h", cyc, mon_vout, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s2_vin = 1'b0; s2_din = '0;
    s1_vin = 1'b0; s1_din = '0;
    idle(2);
    check_reset_state("reset");
    rst_n = 1'b1;
    idle(1);

    // Stride 2, no bubbles: 5,7,13,15 / -1,-3,-9,-11.
    fill(4, 0);
    send_frame(4, 2, 0, 16);
    idle(4);

    // Same frame with a one-cycle gap after every beat.
    send_frame(4, 2, 1, 16);
    idle(4);

    // Abort after beat 6, then a full frame from (0,0).
    send_frame(4, 2, 0, 7);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(4, 2, 0, 16);
    idle(4);

    // Mixed signs and zeros in the first window; all of ch0 negative or zero.
    fill(4, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pv[r][c][0] = -(4 * r + c + 1);
        pb[r][c][0] = i2f(pv[r][c][0]);
      end
    pv[0][0][0] = 0;        pb[0][0][0] = 32'h80000000;  // -0.0
    pv[0][1][0] = 0;        pb[0][1][0] = 32'h00000000;  // +0.0
    pv[1][0][0] = -4;       pb[1][0][0] = 32'hC0600000;  // -3.5
    pv[1][1][0] = -1000000; pb[1][1][0] = 32'hF149F2CA;  // -1e30
    send_frame(4, 2, 0, 16);
    idle(4);

`ifdef MAXPOOL_STRIDE1_EN
    sel = 1;
    idle(2);
    // Stride 1, N=3: 4,5,5,7,8,8,7,8,8; ready low for N+1 cycles.
    fill(3, 0);
    send_frame(3, 1, 0, 9);
    begin
      int lowc = 0;
      while (!mon_rdy && lowc < 20) begin lowc++; @(posedge clk); #1; end
      n_cmp++;
      assert (lowc === 4) else begin
        n_bad++; $error("FAIL drain_len got=%0d expected 4", lowc);
      end
    end
    idle(6);

    // Two frames back-to-back; second is held off by ready_out.
    fill(3, 0);
    send_frame(3, 1, 0, 9);
    fill(3, 100);
    send_frame(3, 1, 0, 9);
    idle(10);
`endif

    idle(6);
    n_cmp++;
    assert (sb.size() === 0) else begin
      n_bad++; $error("FAIL leftover_expected got=%0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
